// File: rtl/instruction_cache_pkg.sv
// instruction_cache_pkg
// Shared definitions for the instruction cache and its line store:
//   - FSM state encodings (IC_IDLE, IC_FILL, IC_RESPOND)
//   - default geometry (index/offset widths) and tag-width helper
//   - memory request/response field widths, common with the data-side
//     load/store buffer
`timescale 1ns/1ps
package instruction_cache_pkg;

  localparam logic [1:0] IC_IDLE    = 2'd0;
  localparam logic [1:0] IC_FILL    = 2'd1;
  localparam logic [1:0] IC_RESPOND = 2'd2;

  localparam int IC_INDEX_WIDTH  = 6;
  localparam int IC_OFFSET_WIDTH = 2;
  localparam int IC_BYTE_WIDTH   = 2;

  localparam int MEM_ADDR_WIDTH = 32;
  localparam int MEM_DATA_WIDTH = 32;

  // Tag is whatever remains of the address above index, word offset and byte bits.
  function automatic int icTagWidth(input int indexWidth, input int offsetWidth);
    return MEM_ADDR_WIDTH - indexWidth - offsetWidth - IC_BYTE_WIDTH;
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// icache_line_store
// Tag / valid / data arrays for a direct-mapped cache.
// Ports:
//   clk_i, rstN_i      clock, synchronous active-low reset (clears valid bits)
//   clearAll_i         bulk invalidate of every line
//   wrEn_i             write wrData_i into word {wrIndex_i, wrOffset_i}
//   setValid_i         mark line wrIndex_i valid with tag setTag_i
//   rdIndex_i/rdOffset_i/lookupTag_i   combinational lookup
//   hit_o, rdData_o    lookup result
`timescale 1ns/1ps
module icache_line_store
  import instruction_cache_pkg::*;
#(
  parameter int INDEX_WIDTH  = IC_INDEX_WIDTH,
  parameter int OFFSET_WIDTH = IC_OFFSET_WIDTH,
  parameter int TAG_WIDTH    = icTagWidth(IC_INDEX_WIDTH, IC_OFFSET_WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      rstN_i,
  input  logic                      clearAll_i,
  input  logic                      wrEn_i,
  input  logic [INDEX_WIDTH-1:0]    wrIndex_i,
  input  logic [OFFSET_WIDTH-1:0]   wrOffset_i,
  input  logic [MEM_DATA_WIDTH-1:0] wrData_i,
  input  logic                      setValid_i,
  input  logic [TAG_WIDTH-1:0]      setTag_i,
  input  logic [INDEX_WIDTH-1:0]    rdIndex_i,
  input  logic [OFFSET_WIDTH-1:0]   rdOffset_i,
  input  logic [TAG_WIDTH-1:0]      lookupTag_i,
  output logic                      hit_o,
  output logic [MEM_DATA_WIDTH-1:0] rdData_o
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int WORDS = 1 << OFFSET_WIDTH;

  logic [LINES-1:0]          valid_q;
  logic [TAG_WIDTH-1:0]      tag_q  [LINES];
  // Data is flattened so that {index, offset} addresses a single word.
  logic [MEM_DATA_WIDTH-1:0] data_q [LINES*WORDS];

  // Bulk clear beats a same-cycle set so an aborted fill never becomes valid.
  always_ff @(posedge clk_i) begin
    if (!rstN_i) begin
      valid_q <= '0;
    end else if (clearAll_i) begin
      valid_q <= '0;
    end else if (setValid_i) begin
      valid_q[wrIndex_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (setValid_i) begin
      tag_q[wrIndex_i] <= setTag_i;
    end
    if (wrEn_i) begin
      data_q[{wrIndex_i, wrOffset_i}] <= wrData_i;
    end
  end

  assign hit_o    = valid_q[rdIndex_i] && (tag_q[rdIndex_i] == lookupTag_i);
  assign rdData_o = data_q[{rdIndex_i, rdOffset_i}];

endmodule

// File: rtl/instruction_cache.sv
// instruction_cache
// Direct-mapped, read-only instruction cache in front of the instruction unit.
// Hits respond one cycle after the request; misses fill the whole line one
// word per memory beat and respond in the cycle after the last beat.
// Ports:
//   clockIn, resetIn (sync, active-low), clearIn (flush + abort fill)
//   pcValid, pcAddr                  fetch request
//   instrValid, instrOut, instrAddr  one-cycle response pulse
//   memReqValid, memReqAddr          word read request to memory
//   memRespValid, memRespData        memory beat
// Optional: define ICACHE_STATS_EN to add hitCount / missCount outputs.
`timescale 1ns/1ps
module instruction_cache
  import instruction_cache_pkg::*;
#(
  parameter int INDEX_WIDTH  = IC_INDEX_WIDTH,
  parameter int OFFSET_WIDTH = IC_OFFSET_WIDTH
) (
  input  logic                      clockIn,
  input  logic                      resetIn,
  input  logic                      clearIn,
  input  logic                      pcValid,
  input  logic [MEM_ADDR_WIDTH-1:0] pcAddr,
  output logic                      instrValid,
  output logic [MEM_DATA_WIDTH-1:0] instrOut,
  output logic [MEM_ADDR_WIDTH-1:0] instrAddr,
  output logic                      memReqValid,
  output logic [MEM_ADDR_WIDTH-1:0] memReqAddr,
  input  logic                      memRespValid,
  input  logic [MEM_DATA_WIDTH-1:0] memRespData
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]               hitCount,
  output logic [31:0]               missCount
`endif
);

  localparam int TAG_WIDTH = icTagWidth(INDEX_WIDTH, OFFSET_WIDTH);
  localparam int WORD_BITS = MEM_ADDR_WIDTH - IC_BYTE_WIDTH;
  localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = '1;

  logic [1:0]                state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] reqAddr_q, reqAddr_d;
  logic [OFFSET_WIDTH-1:0]   count_q, count_d;
  logic                      instrValid_q, instrValid_d;
  logic [MEM_DATA_WIDTH-1:0] instrOut_q, instrOut_d;
  logic [MEM_ADDR_WIDTH-1:0] instrAddr_q, instrAddr_d;
  logic                      memReqValid_q, memReqValid_d;
  logic [MEM_ADDR_WIDTH-1:0] memReqAddr_q, memReqAddr_d;

  logic [WORD_BITS-1:0]      lookupWord;
  logic [INDEX_WIDTH-1:0]    lookupIndex;
  logic [OFFSET_WIDTH-1:0]   lookupOffset;
  logic [TAG_WIDTH-1:0]      lookupTag;
  logic                      lineHit;
  logic [MEM_DATA_WIDTH-1:0] lineData;
  logic                      wrEn;
  logic                      setValid;

  // In IDLE the store is looked up with the live PC; while filling or
  // responding it is addressed by the latched request, so the write port,
  // the tag written on completion and the response bypass all share these fields.
  assign lookupWord   = (state_q == IC_IDLE) ? pcAddr[MEM_ADDR_WIDTH-1:IC_BYTE_WIDTH]
                                             : reqAddr_q[MEM_ADDR_WIDTH-1:IC_BYTE_WIDTH];
  assign lookupOffset = lookupWord[OFFSET_WIDTH-1:0];
  assign lookupIndex  = lookupWord[OFFSET_WIDTH +: INDEX_WIDTH];
  assign lookupTag    = lookupWord[WORD_BITS-1 -: TAG_WIDTH];

  icache_line_store #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .OFFSET_WIDTH(OFFSET_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) lineStore (
    .clk_i      (clockIn),
    .rstN_i     (resetIn),
    .clearAll_i (clearIn),
    .wrEn_i     (wrEn),
    .wrIndex_i  (lookupIndex),
    .wrOffset_i (count_q),
    .wrData_i   (memRespData),
    .setValid_i (setValid),
    .setTag_i   (lookupTag),
    .rdIndex_i  (lookupIndex),
    .rdOffset_i (lookupOffset),
    .lookupTag_i(lookupTag),
    .hit_o      (lineHit),
    .rdData_o   (lineData)
  );

  // instrValid is raised together with the transition into RESPOND, so the
  // RESPOND cycle is the pulse itself and pcValid (still held) is ignored there.
  always_comb begin
    state_d       = state_q;
    reqAddr_d     = reqAddr_q;
    count_d       = count_q;
    instrValid_d  = 1'b0;
    instrOut_d    = instrOut_q;
    instrAddr_d   = instrAddr_q;
    memReqValid_d = memReqValid_q;
    memReqAddr_d  = memReqAddr_q;
    wrEn          = 1'b0;
    setValid      = 1'b0;
    if (clearIn) begin
      state_d       = IC_IDLE;
      memReqValid_d = 1'b0;
      count_d       = '0;
    end else begin
      case (state_q)
        IC_IDLE: begin
          if (pcValid) begin
            if (lineHit) begin
              instrValid_d = 1'b1;
              instrOut_d   = lineData;
              instrAddr_d  = pcAddr;
            end else begin
              reqAddr_d     = pcAddr;
              count_d       = '0;
              state_d       = IC_FILL;
              memReqValid_d = 1'b1;
              memReqAddr_d  = {pcAddr[MEM_ADDR_WIDTH-1:OFFSET_WIDTH+IC_BYTE_WIDTH],
                               (OFFSET_WIDTH+IC_BYTE_WIDTH)'(0)};
            end
          end
        end
        IC_FILL: begin
          if (memRespValid) begin
            wrEn         = 1'b1;
            count_d      = count_q + OFFSET_WIDTH'(1);
            memReqAddr_d = memReqAddr_q + 32'd4;
            if (count_q == LAST_WORD) begin
              setValid      = 1'b1;
              memReqValid_d = 1'b0;
              state_d       = IC_RESPOND;
              instrValid_d  = 1'b1;
              instrAddr_d   = reqAddr_q;
              // The final beat is still on the bus, not yet in the store.
              instrOut_d    = (lookupOffset == LAST_WORD) ? memRespData : lineData;
            end
          end
        end
        IC_RESPOND: state_d = IC_IDLE;
        default:    state_d = IC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      state_q       <= IC_IDLE;
      reqAddr_q     <= '0;
      count_q       <= '0;
      instrValid_q  <= 1'b0;
      instrOut_q    <= '0;
      instrAddr_q   <= '0;
      memReqValid_q <= 1'b0;
      memReqAddr_q  <= '0;
    end else begin
      state_q       <= state_d;
      reqAddr_q     <= reqAddr_d;
      count_q       <= count_d;
      instrValid_q  <= instrValid_d;
      instrOut_q    <= instrOut_d;
      instrAddr_q   <= instrAddr_d;
      memReqValid_q <= memReqValid_d;
      memReqAddr_q  <= memReqAddr_d;
    end
  end

  assign instrValid  = instrValid_q;
  assign instrOut    = instrOut_q;
  assign instrAddr   = instrAddr_q;
  assign memReqValid = memReqValid_q;
  assign memReqAddr  = memReqAddr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hitCount_q, missCount_q;
  logic        hitEvent, missEvent;

  assign hitEvent  = (state_q == IC_IDLE) && !clearIn && pcValid && lineHit;
  assign missEvent = (state_q == IC_IDLE) && !clearIn && pcValid && !lineHit;

  // Statistics survive a flush; only reset zeroes them.
  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      hitCount_q  <= '0;
      missCount_q <= '0;
    end else begin
      if (hitEvent) begin
        hitCount_q <= hitCount_q + 32'd1;
      end
      if (missEvent) begin
        missCount_q <= missCount_q + 32'd1;
      end
    end
  end

  assign hitCount  = hitCount_q;
  assign missCount = missCount_q;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
`timescale 1ns/1ps
module tb_instruction_cache;

  localparam int NLINES = 64;

  logic        clockIn = 1'b0;
  logic        resetIn = 1'b0;
  logic        clearIn = 1'b0;
  logic        pcValid = 1'b0;
  logic [31:0] pcAddr = '0;
  logic        instrValid;
  logic [31:0] instrOut;
  logic [31:0] instrAddr;
  logic        memReqValid;
  logic [31:0] memReqAddr;
  logic        memRespValid = 1'b0;
  logic [31:0] memRespData = '0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hitCount;
  logic [31:0] missCount;
`endif

  int errors = 0;
  int checks = 0;

  // Behavioural model: which lines hold which tag. Memory never changes,
  // so a hit must always return memWord of the requested address.
  bit          mValid [NLINES];
  logic [21:0] mTag   [NLINES];
  int unsigned mHits   = 0;
  int unsigned mMisses = 0;

  // Expected DUT outputs for the current cycle, checked by the monitor.
  logic        expIV  = 1'b0;
  logic [31:0] expIO  = '0;
  logic [31:0] expIA  = '0;
  logic        expMRV = 1'b0;
  logic [31:0] expMRA = '0;
  bit          monOn  = 1'b0;

  instruction_cache dut (
    .clockIn     (clockIn),
    .resetIn     (resetIn),
    .clearIn     (clearIn),
    .pcValid     (pcValid),
    .pcAddr      (pcAddr),
    .instrValid  (instrValid),
    .instrOut    (instrOut),
    .instrAddr   (instrAddr),
    .memReqValid (memReqValid),
    .memReqAddr  (memReqAddr),
    .memRespValid(memRespValid),
    .memRespData (memRespData)
`ifdef ICACHE_STATS_EN
    ,
    .hitCount    (hitCount),
    .missCount   (missCount)
`endif
  );

  initial forever #5 clockIn = ~clockIn;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      32'hC:   return 32'h44;
      default: return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic invalidateModel();
    for (int i = 0; i < NLINES; i++) mValid[i] = 1'b0;
  endtask

  // Per-cycle compare of every meaningful output against the expectations.
  always @(negedge clockIn) begin
    if (monOn) begin
      checkOutput("instrValid", 32'(instrValid), 32'(expIV));
      if (expIV) begin
        checkOutput("instrOut", instrOut, expIO);
        checkOutput("instrAddr", instrAddr, expIA);
      end
      checkOutput("memReqValid", 32'(memReqValid), 32'(expMRV));
      if (expMRV) checkOutput("memReqAddr", memReqAddr, expMRA);
`ifdef ICACHE_STATS_EN
      checkOutput("hitCount", hitCount, mHits);
      checkOutput("missCount", missCount, mMisses);
`endif
    end
  end

  // One fetch. abortAt >= 0 aborts the fill after that many beats (clear, or
  // reset when abortReset); abortAt == -2 raises clear together with the request.
  task automatic applyStimulus(input logic [31:0] addr, input int abortAt, input bit abortReset,
                               input int stallAt, input int stallLen, input bit randResp,
                               output logic [31:0] gotInstr, output logic gotMiss);
    int          idx = int'(addr[9:4]);
    logic [21:0] tg = addr[31:10];
    logic [31:0] base = {addr[31:4], 4'b0000};
    bit          hit;
    bit          resp;
    int          k = 0;
    int          waitCyc = 0;
    int          stallCnt = 0;
    gotInstr = '0;
    gotMiss  = 1'b0;
    hit = mValid[idx] && (mTag[idx] == tg);
    @(negedge clockIn);
    pcValid = 1'b1;
    pcAddr  = addr;
    if (abortAt == -2) begin
      clearIn = 1'b1;
      @(posedge clockIn); #1;
      invalidateModel();
      gotMiss = memReqValid;
      @(negedge clockIn);
      clearIn = 1'b0;
      pcValid = 1'b0;
      return;
    end
    @(posedge clockIn); #1;
    gotMiss = memReqValid;
    if (hit) begin
      mHits++;
      expIV = 1'b1;
      expIO = memWord({addr[31:2], 2'b00});
      expIA = addr;
      gotInstr = instrOut;
      @(negedge clockIn);
      pcValid = 1'b0;
      @(posedge clockIn); #1;
      expIV = 1'b0;
      return;
    end
    mMisses++;
    expMRV = 1'b1;
    expMRA = base;
    while (k < 4) begin
      @(negedge clockIn);
      if (k == abortAt) begin
        memRespValid = 1'($urandom % 2);
        memRespData  = $urandom;
        pcValid = 1'b0;
        if (abortReset) resetIn = 1'b0;
        else clearIn = 1'b1;
        @(posedge clockIn); #1;
        invalidateModel();
        if (abortReset) begin
          mHits = 0;
          mMisses = 0;
        end
        expMRV = 1'b0;
        expIV  = 1'b0;
        @(negedge clockIn);
        clearIn = 1'b0;
        resetIn = 1'b1;
        memRespValid = 1'b1;
        memRespData  = $urandom;
        @(posedge clockIn); #1;
        @(negedge clockIn);
        memRespValid = 1'b0;
        return;
      end
      if (k == stallAt && stallCnt < stallLen) begin
        resp = 1'b0;
        stallCnt++;
      end else if (randResp && waitCyc < 8) begin
        resp = ($urandom % 3) != 0;
      end else begin
        resp = 1'b1;
      end
      waitCyc++;
      memRespValid = resp;
      memRespData  = resp ? memWord(base + 32'(4 * k)) : $urandom;
      @(posedge clockIn); #1;
      if (resp) begin
        k++;
        waitCyc = 0;
        if (k < 4) begin
          expMRA = base + 32'(4 * k);
        end else begin
          expMRV = 1'b0;
          mValid[idx] = 1'b1;
          mTag[idx]   = tg;
          expIV = 1'b1;
          expIO = memWord({addr[31:2], 2'b00});
          expIA = addr;
          gotInstr = instrOut;
        end
      end
    end
    @(negedge clockIn);
    memRespValid = 1'b0;
    pcValid = 1'b0;
    @(posedge clockIn); #1;
    expIV = 1'b0;
  endtask

  task automatic clearPulse();
    @(negedge clockIn);
    clearIn = 1'b1;
    @(posedge clockIn); #1;
    invalidateModel();
    @(negedge clockIn);
    clearIn = 1'b0;
  endtask

  initial begin
    logic [31:0] got;
    logic        miss;
    int          r;
    logic [31:0] a;
    invalidateModel();
    repeat (3) @(posedge clockIn);
    #1;
    checkOutput("rst_instrValid", 32'(instrValid), 32'd0);
    checkOutput("rst_instrOut", instrOut, 32'd0);
    checkOutput("rst_instrAddr", instrAddr, 32'd0);
    checkOutput("rst_memReqValid", 32'(memReqValid), 32'd0);
    checkOutput("rst_memReqAddr", memReqAddr, 32'd0);
    monOn = 1'b1;
    @(negedge clockIn);
    resetIn = 1'b1;

    applyStimulus(32'h0, -1, 1'b0, -1, 0, 1'b0, got, miss);
    checkOutput("t1_miss", 32'(miss), 32'd1);
    checkOutput("t1_instr", got, 32'h11);
    applyStimulus(32'h8, -1, 1'b0, -1, 0, 1'b0, got, miss);
    checkOutput("t2_hit", 32'(miss), 32'd0);
    checkOutput("t2_instr", got, 32'h33);
    applyStimulus(32'h400, -1, 1'b0, -1, 0, 1'b0, got, miss);
    checkOutput("t3_conflict_miss", 32'(miss), 32'd1);
    applyStimulus(32'h0, -1, 1'b0, -1, 0, 1'b0, got, miss);
    checkOutput("t3_remiss", 32'(miss), 32'd1);
    checkOutput("t3_instr", got, 32'h11);

    applyStimulus(32'h20, 2, 1'b0, -1, 0, 1'b0, got, miss);
    applyStimulus(32'h20, -1, 1'b0, -1, 0, 1'b0, got, miss);
    checkOutput("t4_refetch_miss", 32'(miss), 32'd1);

    applyStimulus(32'h44, -1, 1'b0, 2, 5, 1'b0, got, miss);
    checkOutput("t5_stall_miss", 32'(miss), 32'd1);
    applyStimulus(32'h48, -1, 1'b0, -1, 0, 1'b0, got, miss);
    checkOutput("t5_hit_after", 32'(miss), 32'd0);

    applyStimulus(32'h44, -2, 1'b0, -1, 0, 1'b0, got, miss);
    applyStimulus(32'h44, -1, 1'b0, -1, 0, 1'b0, got, miss);
    checkOutput("t6_miss_after_clear", 32'(miss), 32'd1);

    applyStimulus(32'h80, 1, 1'b1, -1, 0, 1'b0, got, miss);
    applyStimulus(32'h100, -1, 1'b0, -1, 0, 1'b0, got, miss);
    applyStimulus(32'h104, -1, 1'b0, -1, 0, 1'b0, got, miss);
    applyStimulus(32'h108, -1, 1'b0, -1, 0, 1'b0, got, miss);
    applyStimulus(32'h10C, -1, 1'b0, -1, 0, 1'b0, got, miss);
    checkOutput("t7_last_hit", 32'(miss), 32'd0);
`ifdef ICACHE_STATS_EN
    checkOutput("stat_miss", missCount, 32'd1);
    checkOutput("stat_hit", hitCount, 32'd3);
`endif
    clearPulse();
`ifdef ICACHE_STATS_EN
    checkOutput("stat_miss_clear", missCount, 32'd1);
    checkOutput("stat_hit_clear", hitCount, 32'd3);
`endif
    applyStimulus(32'h0, -1, 1'b0, -1, 0, 1'b0, got, miss);
    checkOutput("t8_miss_after_reset", 32'(miss), 32'd1);

    for (int n = 0; n < 80; n++) begin
      a = {20'd0, 2'($urandom % 3), 4'd0, 2'($urandom % 4), 2'($urandom % 4), 2'b00};
      r = int'($urandom % 12);
      if (r == 0) applyStimulus(a, int'($urandom % 4), 1'b0, -1, 0, 1'b1, got, miss);
      else if (r == 1) applyStimulus(a, -2, 1'b0, -1, 0, 1'b0, got, miss);
      else if (r == 2) applyStimulus(a, int'($urandom % 4), 1'b1, -1, 0, 1'b1, got, miss);
      else applyStimulus(a, -1, 1'b0, int'($urandom % 4), int'($urandom % 4), 1'b1, got, miss);
      repeat ($urandom % 3) @(negedge clockIn);
    end

    repeat (2) @(negedge clockIn);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_cache.md
Name: instruction_cache

Overview:
- Direct-mapped, read-only instruction cache that sits directly upstream of the instruction unit.
- Accepts PC fetch requests from the instruction unit and returns a 32-bit instruction together with its address.
- On a miss, fills the whole line from the memory controller, one word per memory beat.
- Provides a flush input that invalidates all lines and aborts any in-flight fill.

Parameters:
- INDEX_WIDTH, 6, log2 of the number of lines.
- OFFSET_WIDTH, 2, log2 of words per line (default 4 words = 16 B).

Ports:
- clockIn  input  1  clock.
- resetIn  input  1  reset, synchronous, active-low.
- clearIn  input  1  flush: invalidate all lines, abort any fill.
- pcValid  input  1  fetch request valid (instruction unit instrOutValid).
- pcAddr  input  32  fetch address, word-aligned (instruction unit instrAddrOut).
- instrValid  output  1  returned instruction valid, one-cycle pulse.
- instrOut  output  32  returned instruction.
- instrAddr  output  32  address of instrOut.
- memReqValid  output  1  word read request to the memory controller.
- memReqAddr  output  32  word address being requested.
- memRespValid  input  1  memory data valid for the current request.
- memRespData  input  32  memory data.

Behaviour:
- Reset (resetIn=0 at posedge): all valid bits cleared, state IDLE, instrValid=0, memReqValid=0, instrOut=0, instrAddr=0, memReqAddr=0, fill counter=0.
- Address split: offset=pcAddr[OFFSET_WIDTH+1:2], index=next INDEX_WIDTH bits, tag=remaining upper bits. pcAddr[1:0] is ignored.
- State IDLE:
  - pcValid && hit → at the next posedge, instrValid=1, instrOut=line word, instrAddr=pcAddr. One-cycle hit latency.
  - pcValid && miss → latch the request address; go to FILL with counter=0; memReqValid=1; memReqAddr={tag,index,0,2'b00}.
- State FILL:
  - Each cycle with memRespValid=1: write memRespData into word[counter]; increment counter; advance memReqAddr by 4.
  - memReqValid stays high throughout FILL.
  - When the last word (counter = 2^OFFSET_WIDTH-1) arrives: set valid and tag, drop memReqValid, go to RESPOND.
- State RESPOND: drive instrValid=1 with the requested word (bypassed from the buffer) and the latched address, then return to IDLE.
- instrValid is never high on two consecutive cycles for the same request.
- pcValid is ignored outside IDLE. The instruction unit holds pcValid/pcAddr stable until instrValid.
- clearIn:
  - Takes priority over everything except reset.
  - Clears all valid bits, drops memReqValid and instrValid, and forces IDLE on the next cycle.
  - A partially filled line is not marked valid.
  - memRespValid arriving in the cycle after clear is ignored.
- clearIn together with pcValid in IDLE: the request is dropped, with no response.
- Hit check in the cycle after a fill completes sees the new line.
- Reset mid-FILL: state returns to IDLE with all lines invalid; the memory controller must tolerate the withdrawn request.

Optional Feature:
- ICACHE_STATS_EN defined: adds outputs hitCount[31:0] and missCount[31:0].
  - Both zeroed on reset; not cleared by clearIn; wrap at 2^32.
  - hitCount increments on each IDLE hit; missCount on each IDLE→FILL transition.
- Undefined: the ports and counters are absent, with no behavioural change.

Decomposition:
- Shared package holds:
  - state encodings IC_IDLE=2'd0, IC_FILL=2'd1, IC_RESPOND=2'd2;
  - address field widths derived from the parameters;
  - memory request/response field widths shared with the data-side load/store buffer.
- One sub-module is natural: icache_line_store, the tag/valid/data arrays with a single write port, combinational read, and bulk valid clear.

Test Plan:
- Reset, then pcValid with pcAddr=0x0 → memReqAddr 0x0,0x4,0x8,0xC. Memory returns 0x11,0x22,0x33,0x44 → instrValid one cycle after the last beat, instrOut=0x11, instrAddr=0x0.
- After that fill, request 0x8 → instrValid next cycle, instrOut=0x33, memReqValid stays 0.
- Request 0x400 (same index, different tag at defaults) → miss and refill. A subsequent request to 0x0 misses again.
- clearIn asserted after the 2nd memory beat of a fill for 0x20 → memReqValid drops next cycle, no instrValid. A re-request of 0x20 starts a fresh 4-beat fill from 0x20.
- memRespValid stalled low for 5 cycles mid-fill → memReqValid and memReqAddr held stable, and the fill completes correctly afterwards.
- With ICACHE_STATS_EN: 1 miss followed by 3 hits → missCount=1, hitCount=3. clearIn leaves both unchanged.
